partition_and_preadd_v9: RTL

PARTITION_AND_PREADD_V9 -- requirements
Module: partition_and_preadd_v9

---
 rtl/partition_and_preadd_v9.sv | 135 +++++++++++++
 1 files changed

// File: rtl/partition_and_preadd_v9.sv
// Sample partitioner: zero-extended passthrough lanes, per-group 4:2 carry-save
// preadders with cascade carries, and a windowed running-total monitor.
module partition_and_preadd_v9 #(
  parameter  int DEMUX   = 16,
  parameter  int INBITS  = 3,
  parameter  int DSPBITS = 12,
  parameter  int NDIRECT = 8,
  parameter  int ACCLOG2 = 10,
  localparam int NGROUP  = (DEMUX - NDIRECT) / 4,
  localparam int ACCBITS = INBITS + $clog2(DEMUX) + ACCLOG2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEMUX*INBITS-1:0]     IN,
  input  logic                        IN_VALID,
  input  logic [2*NGROUP-1:0]         CARRYIN,
  output logic [NDIRECT*DSPBITS-1:0]  DIRECT,
  output logic [NGROUP*DSPBITS-1:0]   PREADD_S,
  output logic [NGROUP*DSPBITS-1:0]   PREADD_C,
  output logic                        PREADD_VALID,
  output logic [ACCBITS-1:0]          WIN_SUM,
  output logic                        WIN_VALID
);

  localparam int TBITS = INBITS + $clog2(DEMUX);
  localparam int LANEW = INBITS + 1;
  localparam int CNTW  = (ACCLOG2 > 0) ? ACCLOG2 : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((2 ** ACCLOG2) - 1);

  generate
    if (((DEMUX - NDIRECT) % 4) != 0 || NDIRECT < 0 || (INBITS + 1) > DSPBITS) begin : g_bad_cfg
      $error("partition_and_preadd_v9: unsupported DEMUX/NDIRECT/INBITS/DSPBITS combination");
    end
  endgenerate

  for (genvar k = 0; k < NDIRECT; k++) begin : g_direct
    assign DIRECT[DSPBITS*k +: DSPBITS] = DSPBITS'(IN[INBITS*k +: INBITS]);
  end

  logic [NGROUP*DSPBITS-1:0] pre_s_d, pre_s_q;
  logic [NGROUP*DSPBITS-1:0] pre_c_d, pre_c_q;
  logic                      pre_valid_q;

  for (genvar g = 0; g < NGROUP; g++) begin : g_group
    logic [INBITS-1:0] a, b, c, d;
    logic [INBITS-1:0] s1, c1;
    logic [LANEW-1:0]  x, y, z, s2;
    logic [INBITS-1:0] c2;

    assign a = IN[INBITS*(NDIRECT+4*g+0) +: INBITS];
    assign b = IN[INBITS*(NDIRECT+4*g+1) +: INBITS];
    assign c = IN[INBITS*(NDIRECT+4*g+2) +: INBITS];
    assign d = IN[INBITS*(NDIRECT+4*g+3) +: INBITS];

    assign s1 = a ^ b ^ c;
    assign c1 = (a & b) | (a & c) | (b & c);

    // Level-1 carries shift up one place, leaving bit 0 free for the cascade carry.
    assign x  = {1'b0, s1};
    assign y  = {c1, CARRYIN[2*g]};
    assign z  = {1'b0, d};
    assign s2 = x ^ y ^ z;
    // Top carry bit is always 0 because x and z have a zero MSB.
    assign c2 = (x[INBITS-1:0] & y[INBITS-1:0]) | (x[INBITS-1:0] & z[INBITS-1:0])
              | (y[INBITS-1:0] & z[INBITS-1:0]);

    assign pre_s_d[DSPBITS*g +: DSPBITS] = DSPBITS'(s2);
    assign pre_c_d[DSPBITS*g +: DSPBITS] = DSPBITS'({c2, CARRYIN[2*g+1]});
  end

  logic [TBITS-1:0]   t_d, t_q;
  logic               t_valid_q;
  logic [ACCBITS-1:0] acc_d, acc_q;
  logic [CNTW-1:0]    cnt_d, cnt_q;
  logic [ACCBITS-1:0] win_sum_d, win_sum_q;
  logic               win_valid_d, win_valid_q;

  always_comb begin
    t_d = '0;
    for (int i = 0; i < DEMUX; i++) begin
      t_d = t_d + TBITS'(IN[INBITS*i +: INBITS]);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    win_sum_d   = win_sum_q;
    win_valid_d = 1'b0;
    if (t_valid_q) begin
      if (cnt_q == CNT_LAST) begin
        win_sum_d   = acc_q + ACCBITS'(t_q);
        win_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_q + ACCBITS'(t_q);
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_s_q     <= '0;
      pre_c_q     <= '0;
      pre_valid_q <= 1'b0;
      t_q         <= '0;
      t_valid_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      win_sum_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      pre_s_q     <= pre_s_d;
      pre_c_q     <= pre_c_d;
      pre_valid_q <= IN_VALID;
      if (IN_VALID) t_q <= t_d;
      t_valid_q   <= IN_VALID;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      win_sum_q   <= win_sum_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign PREADD_S     = pre_s_q;
  assign PREADD_C     = pre_c_q;
  assign PREADD_VALID = pre_valid_q;
  assign WIN_SUM      = win_sum_q;
  assign WIN_VALID    = win_valid_q;

endmodule
